// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding,
// byte-enable constants, requester identifiers and address helpers.
package mips_mem_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GRANT_IF = 2'd1;
    localparam logic [1:0] S_GRANT_D  = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    // All four byte lanes enabled (word access)
    localparam logic [3:0] BE_WORD = 4'hF;

    // Requester identifiers, used for round-robin and response routing
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    // Memory is addressed by word; the low two bits are always cleared
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: a request/ready handshake with
// word address, byte enables and data in both directions.
interface mem_port_arbiter_if;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    // Arbiter side drives the request
    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    // Memory side answers it
    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane formatting: store-side byte enables / lane replication and
// load-side byte extraction with sign or zero extension. Purely combinational.
module mem_byte_lane
    import mips_mem_pkg::*;
(
    input  logic        st_byte,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_lane,

    input  logic        ld_byte,
    input  logic        ld_sign,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0] ld_byte_val;

    // Store formatting: a byte store is replicated to every lane so the
    // selected enable picks the right one regardless of offset
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        st_be         = BE_WORD;
        st_wdata_lane = st_wdata;
        if (st_byte) begin
            st_be         = 4'b0001 << st_addr_lo;
            st_wdata_lane = {4{st_wdata[7:0]}};
        end
    end

    // Load formatting: pick the addressed byte and extend it to 32 bits
    always_comb begin
        ld_byte_val = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_data     = ld_rdata;
        if (ld_byte) begin
            ld_data = {{24{ld_sign & ld_byte_val[7]}}, ld_byte_val};
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data
// access. One transaction at a time, round-robin when both request,
// with misalignment and timeout errors and fetch suppression while halted.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic        d_sign,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,

    input  logic        halted,
    output logic        idle,

    mem_port_arbiter_if.master mem
);

    logic [1:0]       state_q, state_d;
    req_id_e          last_q, last_d;
    req_id_e          cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             byte_q, byte_d;
    logic             sign_q, sign_d;
    logic [1:0]       lo_q, lo_d;

    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      ld_data;
    logic             if_ok;
    logic             pick_d;
    logic             pick_if;
    logic             resp;

    mem_byte_lane u_lane (
        .st_byte       (d_byte),
        .st_addr_lo    (d_addr[1:0]),
        .st_wdata      (d_wdata),
        .st_be         (lane_be),
        .st_wdata_lane (lane_wdata),
        .ld_byte       (byte_q),
        .ld_sign       (sign_q),
        .ld_addr_lo    (lo_q),
        .ld_rdata      (rdata_q),
        .ld_data       (ld_data)
    );

    // Arbitration: fetch is ineligible while halted; on contention the
    // requester not granted last wins
    always_comb begin
        if_ok   = if_req && !halted;
        pick_d  = d_req && (!if_ok || last_q == REQ_IF);
        pick_if = if_ok && !pick_d;
    end

    // Next-state and transaction-register logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        byte_d  = byte_q;
        sign_d  = sign_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                if (pick_d) begin
                    cur_d  = REQ_D;
                    byte_d = d_byte;
                    sign_d = d_sign;
                    lo_d   = d_addr[1:0];
                    if (!d_byte && d_addr[1:0] != 2'b00) begin
                        // Misaligned word: answer with an error, never touch memory
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        we_d    = d_we;
                        be_d    = lane_be;
                        addr_d  = word_addr(d_addr);
                        wdata_d = lane_wdata;
                        state_d = S_GRANT_D;
                    end
                end else if (pick_if) begin
                    cur_d   = REQ_IF;
                    byte_d  = 1'b0;
                    sign_d  = 1'b0;
                    lo_d    = 2'b00;
                    we_d    = 1'b0;
                    be_d    = BE_WORD;
                    addr_d  = word_addr(if_addr);
                    wdata_d = '0;
                    state_d = S_GRANT_IF;
                end
            end
            S_GRANT_IF, S_GRANT_D: begin
                if (mem.mem_ready) begin
                    rdata_d = mem.mem_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                last_d  = cur_q;
                we_d    = 1'b0;
                be_d    = '0;
                addr_d  = '0;
                wdata_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset also drops mem_req at once since it decodes state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= REQ_IF;
            cur_q   <= REQ_IF;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            byte_q  <= 1'b0;
            sign_q  <= 1'b0;
            lo_q    <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            byte_q  <= byte_d;
            sign_q  <= sign_d;
            lo_q    <= lo_d;
        end
    end

    // Output decode: acks pulse only in RESP, read data is zero outside an ack or on error
    always_comb begin
        resp          = (state_q == S_RESP);
        idle          = (state_q == S_IDLE);
        mem.mem_req   = (state_q == S_GRANT_IF) || (state_q == S_GRANT_D);
        mem.mem_we    = we_q;
        mem.mem_be    = be_q;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = wdata_q;
        if_ack        = resp && (cur_q == REQ_IF);
        d_ack         = resp && (cur_q == REQ_D);
        if_err        = if_ack && err_q;
        d_err         = d_ack && err_q;
        if_rdata      = (if_ack && !err_q) ? rdata_q : 32'h0;
        d_rdata       = (d_ack && !err_q) ? ld_data : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: LW latency, round-robin,
// byte loads/stores, misalignment, fetch timeout, reset and halt behaviour.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic        d_sign;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        halted;
    logic        idle;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter_if mem_bus ();

    mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_byte   (d_byte),
        .d_sign   (d_sign),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .d_err    (d_err),
        .halted   (halted),
        .idle     (idle),
        .mem      (mem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic clear_reqs();
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_byte  = 1'b0;
        d_sign  = 1'b0;
    endtask

    // Answer the current mem_req after 'gap' wait cycles; returns in RESP
    task automatic mem_answer(input int gap, input logic [31:0] data);
        repeat (gap) tick();
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = data;
        tick();
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        if_addr = 32'h0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        halted  = 1'b0;
        clear_reqs();
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        tick();
        tick();

        // Reset state
        check("rst_mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
        check("rst_idle", {31'b0, idle}, 32'd1);
        check("rst_acks", {30'b0, if_ack, d_ack}, 32'd0);
        check("rst_be", {28'b0, mem_bus.mem_be}, 32'd0);
        rst_n = 1'b1;
        tick();

        // LW 0x100, mem_ready on the second mem_req cycle
        d_req = 1'b1; d_addr = 32'h100;
        tick();
        check("lw_mem_req", {31'b0, mem_bus.mem_req}, 32'd1);
        check("lw_be", {28'b0, mem_bus.mem_be}, 32'hF);
        check("lw_addr", mem_bus.mem_addr, 32'h100);
        check("lw_we", {31'b0, mem_bus.mem_we}, 32'd0);
        check("lw_idle_busy", {31'b0, idle}, 32'd0);
        mem_answer(1, 32'hDEADBEEF);
        check("lw_ack", {31'b0, d_ack}, 32'd1);
        check("lw_rdata", d_rdata, 32'hDEADBEEF);
        check("lw_err", {31'b0, d_err}, 32'd0);
        check("lw_req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
        clear_reqs();
        tick();
        check("lw_ack_pulse", {31'b0, d_ack}, 32'd0);
        check("lw_idle", {31'b0, idle}, 32'd1);

        // Round-robin from reset: data first, then alternate
        do_reset();
        if_req = 1'b1; if_addr = 32'h200;
        d_req  = 1'b1; d_addr  = 32'h104;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_addr", mem_bus.mem_addr, (i % 2 == 0) ? 32'h104 : 32'h200);
            mem_answer(0, 32'hA000_0000 + i);
            check("rr_ack", {30'b0, d_ack, if_ack}, (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i % 2 == 1) check("rr_if_rdata", if_rdata, 32'hA000_0000 + i);
            tick();
        end
        clear_reqs();
        tick();

        // LB 0x103, sign and zero extension
        for (int s = 1; s >= 0; s--) begin
            d_req = 1'b1; d_byte = 1'b1; d_sign = s[0]; d_addr = 32'h103;
            tick();
            check("lb_be", {28'b0, mem_bus.mem_be}, 32'h8);
            check("lb_addr", mem_bus.mem_addr, 32'h100);
            mem_answer(0, 32'h80FF_FF7F);
            check("lb_rdata", d_rdata, s ? 32'hFFFF_FF80 : 32'h0000_0080);
            clear_reqs();
            tick();
        end

        // SB 0x102
        d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 32'h102; d_wdata = 32'h12345678;
        tick();
        check("sb_be", {28'b0, mem_bus.mem_be}, 32'h4);
        check("sb_wdata", mem_bus.mem_wdata, 32'h78787878);
        check("sb_we", {31'b0, mem_bus.mem_we}, 32'd1);
        mem_answer(2, 32'h0);
        check("sb_ack", {31'b0, d_ack}, 32'd1);
        clear_reqs();
        tick();

        // SW 0x101: misaligned, no memory access
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h101;
        tick();
        check("sw_mis_mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
        check("sw_mis_ack_err", {30'b0, d_ack, d_err}, 32'd3);
        clear_reqs();
        tick();

        // Fetch timeout: mem_ready never arrives
        if_req = 1'b1; if_addr = 32'h300;
        n = 0;
        do begin
            tick();
            n++;
        end while (!if_ack && n < 40);
        check("to_latency", n, 32'd17);
        check("to_if_err", {31'b0, if_err}, 32'd1);
        check("to_if_rdata", if_rdata, 32'h0);
        check("to_mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
        tick();

        // Reset mid-transaction drops mem_req asynchronously
        if_addr = 32'h400;
        tick();
        tick();
        check("mid_mem_req", {31'b0, mem_bus.mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_drop", {31'b0, mem_bus.mem_req}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("regrant_req", {31'b0, mem_bus.mem_req}, 32'd1);
        check("regrant_addr", mem_bus.mem_addr, 32'h400);
        mem_answer(0, 32'h1234_0000);
        check("regrant_ack", {31'b0, if_ack}, 32'd1);
        tick();

        // Reset with halted=1: pending fetch is blocked, data still served
        tick();
        #2 rst_n = 1'b0;
        halted = 1'b1;
        #1 rst_n = 1'b1;
        tick();
        tick();
        check("halt_block", {31'b0, mem_bus.mem_req}, 32'd0);
        check("halt_idle", {31'b0, idle}, 32'd1);
        d_req = 1'b1; d_addr = 32'h108;
        tick();
        check("halt_d_addr", mem_bus.mem_addr, 32'h108);
        mem_answer(0, 32'h5555_AAAA);
        check("halt_d_ack", {31'b0, d_ack}, 32'd1);
        d_req = 1'b0;
        tick();
        halted = 1'b0;
        tick();
        check("unhalt_addr", mem_bus.mem_addr, 32'h400);
        check("unhalt_req", {31'b0, mem_bus.mem_req}, 32'd1);
        mem_answer(0, 32'h0);
        clear_reqs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
